regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write channel between the in-order pipeline writeback and a long-latency unit (multiplier/divider/load miss path).
- Buffers long-latency results in a small FIFO and enforces anti-starvation by requesting a pipeline stall.
- Keeps a per-register pending scoreboard so decode can detect RAW/WAW hazards against outstanding long ops.
- Sits between the writeback stage, the long-latency unit and the register-file write channel.

Parameters:
- DEPTH, 2: result FIFO entries; power of 2, minimum 2.
- MAX_WAIT, 4: maximum cycles a non-empty FIFO head may be denied before stall_req is raised; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pipe_wen  in  1  pipeline writeback request
- pipe_waddr  in  5  pipeline destination register
- pipe_wdata  in  32  pipeline write data
- lu_valid  in  1  long-unit result valid
- lu_ready  out  1  FIFO can accept a result
- lu_waddr  in  5  long-unit destination register
- lu_wdata  in  32  long-unit result
- lu_issue  in  1  long op issued this cycle; marks its destination pending
- lu_issue_addr  in  5  destination of the issued op
- chk_addr_1  in  5  decode read address 1
- chk_addr_2  in  5  decode read address 2
- hazard_1  out  1  chk_addr_1 awaits a long-unit result
- hazard_2  out  1  chk_addr_2 awaits a long-unit result
- stall_req  out  1  registered; pipeline must hold writeback this cycle
- rf_write_en  out  1  register-file write enable
- rf_write_addr  out  5  register-file write address
- rf_write_data  out  32  register-file write data

Behaviour:
- Reset (rst=1 at posedge): FIFO emptied, pending[31:0]=0, wait_cnt=0, stall_req=0. While rst=1, lu_ready, rf_write_en, hazard_1 and hazard_2 are forced to 0.
- Request qualification: a request with destination 0 counts as no request. lu_valid with lu_waddr=0 is still handshaken (lu_ready honoured) but is discarded; nothing is pushed.
- FIFO handshake:
  - lu_ready = !full.
  - Push on lu_valid && lu_ready.
  - A push and a pop in the same cycle are both legal. When full, lu_ready=0 even if a pop occurs that cycle; no combinational pass-through.
  - Push into an empty FIFO is visible at the head on the next cycle.
- Grant (combinational each cycle, priority order):
  1. stall_req=1 and FIFO non-empty: head written, popped; pipe_wen ignored (pipeline holds).
  2. pipe_wen qualified: pipeline written; head waits.
  3. FIFO non-empty: head written, popped.
  4. Otherwise rf_write_en=0.
- rf_write_* are combinational from the selected source, zero-latency.
- wait_cnt:
  - Increments each cycle the FIFO is non-empty and the head is not granted.
  - Clears on a head grant, or when the FIFO is empty.
  - Saturates at MAX_WAIT-1.
- stall_req:
  - Next value is 1 iff, at this posedge, the FIFO stays non-empty, the head was not granted, and wait_cnt==MAX_WAIT-1.
  - Otherwise next value is 0, so each stall lasts exactly one cycle.
- Scoreboard:
  - lu_issue with lu_issue_addr≠0 sets pending[addr].
  - A head write clears pending[head addr].
  - Set and clear on the same address in the same cycle: set wins.
- hazard_n = pending[chk_addr_n] && chk_addr_n≠0 && !(head granted && head addr==chk_addr_n). The register file forwards same-cycle write data, so the write cycle is hazard-free.
- Preconditions (asserted in the bench, not handled by RTL):
  - At most one outstanding long op per register.
  - The pipeline never writes a register whose pending bit is set.
  - Long-unit results arrive in issue order.

Test Plan:
- Reset mid-operation: FIFO holds 2 entries, pending[5]=1, stall_req=1, then rst for 1 cycle → lu_ready=0 and rf_write_en=0 during rst; next cycle FIFO empty, hazard_1=0 for chk_addr_1=5, stall_req=0.
- Idle pipeline: lu_issue addr 7, then lu_valid addr 7 data 0xDEADBEEF, pipe_wen=0 → write 0xDEADBEEF to r7 the cycle after the push; hazard_1 for r7 is 1 from the cycle after issue until the write cycle, and 0 in the write cycle.
- Contention: pipe_wen=1 every cycle (addr 3), one FIFO entry for r9, MAX_WAIT=4 → pipeline wins for 4 cycles, stall_req=1 in cycle 5, r9 written in cycle 5, pipeline resumes in cycle 6.
- Full FIFO: DEPTH=2, pipe_wen continuously, 3 back-to-back lu_valid → lu_ready drops after 2 pushes; third result held until a stall-driven pop; the three results are written in order.
- $0 handling: lu_valid with addr 0 and data 0x1234 → handshake completes, no push, no write; pipe_wen with addr 0 → rf_write_en=0; hazard with chk_addr=0 is always 0.
- Same-cycle set/clear: head writes r4 while lu_issue addr 4 → pending[4]=1 afterwards, hazard on r4 asserted next cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write channel between the in-order pipeline
// writeback and a long-latency unit. Long-unit results are buffered in a small
// FIFO. A pipeline write normally wins over the FIFO head. If the head has been
// denied for MAX_WAIT cycles, a one-cycle stall_req is raised so the head drains.
// A per-register pending scoreboard lets decode see hazards against long ops
// that are still outstanding.
//
// Handshake: lu_valid/lu_ready follow strict valid/ready semantics. A transfer
// happens on a posedge where both are high. lu_ready depends only on FIFO
// occupancy and rst, never on lu_valid or on a same-cycle pop.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   pipe_wen/waddr/wdata           pipeline writeback request
//   lu_valid/ready/waddr/wdata     long-unit result channel (into the FIFO)
//   lu_issue, lu_issue_addr        long op issued; marks its destination pending
//   chk_addr_1/2, hazard_1/2       decode hazard lookup
//   stall_req                      registered; pipeline must hold writeback
//   rf_write_en/addr/data          register-file write channel (combinational)
module regfile_wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wen,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    input  logic        lu_issue,
    input  logic [4:0]  lu_issue_addr,
    input  logic [4:0]  chk_addr_1,
    input  logic [4:0]  chk_addr_2,
    output logic        hazard_1,
    output logic        hazard_2,
    output logic        stall_req,
    output logic        rf_write_en,
    output logic [4:0]  rf_write_addr,
    output logic [31:0] rf_write_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

    logic [4:0]    r_fifo_addr [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [WW-1:0] r_wait_cnt;
    logic          r_stall;
    logic [31:0]   r_pending;

    logic          w_empty;
    logic          w_full;
    logic          w_pipe_req;
    logic          w_push;
    logic          w_pop;
    logic [4:0]    w_head_addr;
    logic [31:0]   w_head_data;
    logic [AW:0]   w_count_next;
    logic          w_stall_next;
    logic [31:0]   w_pending_next;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_FULL);
    assign w_head_addr = r_fifo_addr[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];

    // Destination r0 is architecturally constant, so such requests are dropped.
    assign w_pipe_req = pipe_wen && (pipe_waddr != 5'd0);

    // Address-0 results still complete the handshake but never enter the FIFO,
    // so every FIFO entry has a non-zero destination.
    assign lu_ready = !rst && !w_full;
    assign w_push   = lu_valid && lu_ready && (lu_waddr != 5'd0);

    // Head wins when a stall is in force, or when the pipeline has nothing to write.
    assign w_pop = !w_empty && (r_stall || !w_pipe_req);

    assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

    // Stall only for a head that was present and denied this cycle; a push into
    // an empty FIFO does not count as a denial.
    assign w_stall_next = !w_empty && !w_pop && (w_count_next != '0) &&
                          (r_wait_cnt == WAIT_LAST);

    always_comb begin
        rf_write_en   = 1'b0;
        rf_write_addr = 5'd0;
        rf_write_data = 32'd0;
        if (!rst) begin
            if (w_pop) begin
                rf_write_en   = 1'b1;
                rf_write_addr = w_head_addr;
                rf_write_data = w_head_data;
            end else if (w_pipe_req) begin
                rf_write_en   = 1'b1;
                rf_write_addr = pipe_waddr;
                rf_write_data = pipe_wdata;
            end
        end
    end

    // Clear on head write first, then set, so a same-cycle set on the same
    // register survives.
    always_comb begin
        w_pending_next = r_pending;
        if (w_pop) begin
            w_pending_next[w_head_addr] = 1'b0;
        end
        if (lu_issue && (lu_issue_addr != 5'd0)) begin
            w_pending_next[lu_issue_addr] = 1'b1;
        end
    end

    // The register file forwards same-cycle write data, so a register being
    // written by the head this cycle is already hazard-free.
    assign hazard_1 = !rst && (chk_addr_1 != 5'd0) && r_pending[chk_addr_1] &&
                      !(w_pop && (w_head_addr == chk_addr_1));
    assign hazard_2 = !rst && (chk_addr_2 != 5'd0) && r_pending[chk_addr_2] &&
                      !(w_pop && (w_head_addr == chk_addr_2));

    assign stall_req = r_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_wait_cnt <= '0;
            r_stall    <= 1'b0;
            r_pending  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wptr] <= lu_waddr;
                r_fifo_data[r_wptr] <= lu_wdata;
                r_wptr              <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_next;

            if (w_empty || w_pop) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != WAIT_LAST) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            r_stall   <= w_stall_next;
            r_pending <= w_pending_next;
        end
    end

endmodule
